// File: rtl/proc_hier_pkg.sv
// Shared types and defaults for the proc_hier statistics/trace block.
package proc_hier_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int NUM_CTR   = 7;

  typedef logic [15:0] word_t;
  typedef logic [2:0]  reg_num_t;

  typedef struct packed {
    logic     reg_vld;
    logic     ld_vld;
    logic     st_vld;
    reg_num_t reg_num;
    word_t    reg_data;
    word_t    addr;
    word_t    data;
  } trace_t;

endpackage

// File: rtl/proc_hier_ctr.sv
// Saturating up-counter with async reset and increment enable.
module proc_hier_ctr #(
  parameter int W = proc_hier_pkg::CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  // Holds at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_reg <= '0;
    else if (en && (count_reg != {W{1'b1}}))
      count_reg <= count_reg + 1'b1;
  end

  assign count = count_reg;

endmodule

// File: rtl/proc_hier.sv
// Commit-stage statistics counters, sticky halt and optional registered commit trace.
// Trace registers exist only when PROC_HIER_TRACE_EN is defined; otherwise trace outputs are 0.
module proc_hier
  import proc_hier_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      pc,
  input  logic [15:0]      inst,
  input  logic             reg_write,
  input  logic [2:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             mem_done,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data_in,
  input  logic [15:0]      mem_data_out,
  input  logic             icache_hit,
  input  logic             dcache_hit,
  input  logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] icache_req_count,
  output logic [CNT_W-1:0] icache_hit_count,
  output logic [CNT_W-1:0] dcache_req_count,
  output logic [CNT_W-1:0] dcache_hit_count,
  output logic             trace_reg_vld,
  output logic             trace_ld_vld,
  output logic             trace_st_vld,
  output logic [2:0]       trace_reg_num,
  output logic [15:0]      trace_reg_data,
  output logic [15:0]      trace_addr,
  output logic [15:0]      trace_data
);

  logic halted_reg;
  logic active;
  logic ld;
  logic st;
  logic commit;

  assign active = ~halted_reg;
  assign ld     = mem_read & mem_done;
  assign st     = mem_write & mem_done;
  assign commit = halt | reg_write | st;

  // The halt cycle itself is still active, so its events are counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halted_reg <= 1'b0;
    else if (active && halt)
      halted_reg <= 1'b1;
  end

  assign halted = halted_reg;

  logic [NUM_CTR-1:0] inc_cond;
  logic [CNT_W-1:0]   counts [NUM_CTR];

  assign inc_cond[0] = 1'b1;
  assign inc_cond[1] = commit;
  assign inc_cond[2] = 1'b1;
  assign inc_cond[3] = icache_hit;
  assign inc_cond[4] = ld | st;
  assign inc_cond[5] = dcache_hit & (ld | st);
  assign inc_cond[6] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CTR - 1; gi++) begin : g_ctr
      proc_hier_ctr #(.W(CNT_W)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .en    (active & inc_cond[gi]),
        .count (counts[gi])
      );
    end
  endgenerate

  assign cycle_count      = counts[0];
  assign inst_count       = counts[1];
  assign icache_req_count = counts[2];
  assign icache_hit_count = counts[3];
  assign dcache_req_count = counts[4];
  assign dcache_hit_count = counts[5];

`ifdef PROC_HIER_TRACE_EN
  trace_t trace_reg;

  // Valids drop while halted; payload keeps the last active sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trace_reg <= '0;
    end else if (active) begin
      trace_reg.reg_vld  <= reg_write;
      trace_reg.ld_vld   <= ld;
      trace_reg.st_vld   <= st;
      trace_reg.reg_num  <= write_reg;
      trace_reg.reg_data <= write_data;
      trace_reg.addr     <= mem_addr;
      trace_reg.data     <= ld ? mem_data_out : mem_data_in;
    end else begin
      trace_reg.reg_vld <= 1'b0;
      trace_reg.ld_vld  <= 1'b0;
      trace_reg.st_vld  <= 1'b0;
    end
  end

  assign trace_reg_vld  = trace_reg.reg_vld;
  assign trace_ld_vld   = trace_reg.ld_vld;
  assign trace_st_vld   = trace_reg.st_vld;
  assign trace_reg_num  = trace_reg.reg_num;
  assign trace_reg_data = trace_reg.reg_data;
  assign trace_addr     = trace_reg.addr;
  assign trace_data     = trace_reg.data;
`else
  assign trace_reg_vld  = 1'b0;
  assign trace_ld_vld   = 1'b0;
  assign trace_st_vld   = 1'b0;
  assign trace_reg_num  = '0;
  assign trace_reg_data = '0;
  assign trace_addr     = '0;
  assign trace_data     = '0;
`endif

endmodule

// File: tb/tb_proc_hier.sv
// Self-checking bench for proc_hier: directed scenarios plus randomized traffic
// compared every cycle against an unbounded-count behavioural model.
module tb_proc_hier;

`ifdef PROC_HIER_TRACE_EN
  localparam bit TRACE_ON = 1'b1;
`else
  localparam bit TRACE_ON = 1'b0;
`endif

  logic        clk, rst;
  logic [15:0] pc, inst, write_data, mem_addr, mem_data_in, mem_data_out;
  logic [2:0]  write_reg;
  logic        reg_write, mem_read, mem_write, mem_done, icache_hit, dcache_hit, halt;

  logic        halted;
  logic [31:0] cycle_count, inst_count, icache_req_count, icache_hit_count;
  logic [31:0] dcache_req_count, dcache_hit_count;
  logic        trace_reg_vld, trace_ld_vld, trace_st_vld;
  logic [2:0]  trace_reg_num;
  logic [15:0] trace_reg_data, trace_addr, trace_data;

  logic        s_halted;
  logic [3:0]  s_cyc, s_inst, s_ireq, s_ihit, s_dreq, s_dhit;
  logic        s_rv, s_lv, s_sv;
  logic [2:0]  s_rn;
  logic [15:0] s_rd, s_addr, s_data;

  proc_hier #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_done(mem_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .icache_hit(icache_hit), .dcache_hit(dcache_hit), .halt(halt),
    .halted(halted), .cycle_count(cycle_count), .inst_count(inst_count),
    .icache_req_count(icache_req_count), .icache_hit_count(icache_hit_count),
    .dcache_req_count(dcache_req_count), .dcache_hit_count(dcache_hit_count),
    .trace_reg_vld(trace_reg_vld), .trace_ld_vld(trace_ld_vld), .trace_st_vld(trace_st_vld),
    .trace_reg_num(trace_reg_num), .trace_reg_data(trace_reg_data),
    .trace_addr(trace_addr), .trace_data(trace_data)
  );

  proc_hier #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_done(mem_done),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .icache_hit(icache_hit), .dcache_hit(dcache_hit), .halt(halt),
    .halted(s_halted), .cycle_count(s_cyc), .inst_count(s_inst),
    .icache_req_count(s_ireq), .icache_hit_count(s_ihit),
    .dcache_req_count(s_dreq), .dcache_hit_count(s_dhit),
    .trace_reg_vld(s_rv), .trace_ld_vld(s_lv), .trace_st_vld(s_sv),
    .trace_reg_num(s_rn), .trace_reg_data(s_rd),
    .trace_addr(s_addr), .trace_data(s_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: unbounded event tallies, saturation applied when compared.
  longint m_cyc, m_inst, m_ireq, m_ihit, m_dreq, m_dhit;
  bit     m_halted;
  bit     m_rv, m_lv, m_sv;
  logic [2:0]  m_rn;
  logic [15:0] m_rd, m_addr, m_data;

  function automatic logic [63:0] sat(input longint x, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (x > mx) ? mx : x;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit ld, st;
    if (rst) begin
      m_cyc = 0; m_inst = 0; m_ireq = 0; m_ihit = 0; m_dreq = 0; m_dhit = 0;
      m_halted = 0; m_rv = 0; m_lv = 0; m_sv = 0;
      m_rn = 0; m_rd = 0; m_addr = 0; m_data = 0;
    end else if (!m_halted) begin
      ld = mem_read && mem_done;
      st = mem_write && mem_done;
      m_cyc  += 1;
      m_ireq += 1;
      if (halt || reg_write || st) m_inst += 1;
      if (icache_hit) m_ihit += 1;
      if (ld || st) m_dreq += 1;
      if (dcache_hit && (ld || st)) m_dhit += 1;
      m_rv = reg_write; m_lv = ld; m_sv = st;
      m_rn = write_reg; m_rd = write_data; m_addr = mem_addr;
      m_data = ld ? mem_data_out : mem_data_in;
      if (halt) m_halted = 1;
    end else begin
      m_rv = 0; m_lv = 0; m_sv = 0;
    end
  end

  // Single compare process, mid-cycle on the falling edge.
  always @(negedge clk) begin
    chk("halted", halted, m_halted);
    chk("cycle_count", cycle_count, sat(m_cyc, 32));
    chk("inst_count", inst_count, sat(m_inst, 32));
    chk("icache_req_count", icache_req_count, sat(m_ireq, 32));
    chk("icache_hit_count", icache_hit_count, sat(m_ihit, 32));
    chk("dcache_req_count", dcache_req_count, sat(m_dreq, 32));
    chk("dcache_hit_count", dcache_hit_count, sat(m_dhit, 32));
    chk("trace_reg_vld", trace_reg_vld, TRACE_ON ? m_rv : 1'b0);
    chk("trace_ld_vld", trace_ld_vld, TRACE_ON ? m_lv : 1'b0);
    chk("trace_st_vld", trace_st_vld, TRACE_ON ? m_sv : 1'b0);
    chk("trace_reg_num", trace_reg_num, TRACE_ON ? m_rn : 3'd0);
    chk("trace_reg_data", trace_reg_data, TRACE_ON ? m_rd : 16'd0);
    chk("trace_addr", trace_addr, TRACE_ON ? m_addr : 16'd0);
    chk("trace_data", trace_data, TRACE_ON ? m_data : 16'd0);
    chk("w4_halted", s_halted, m_halted);
    chk("w4_cycle_count", s_cyc, sat(m_cyc, 4));
    chk("w4_inst_count", s_inst, sat(m_inst, 4));
    chk("w4_icache_req_count", s_ireq, sat(m_ireq, 4));
    chk("w4_icache_hit_count", s_ihit, sat(m_ihit, 4));
    chk("w4_dcache_req_count", s_dreq, sat(m_dreq, 4));
    chk("w4_dcache_hit_count", s_dhit, sat(m_dhit, 4));
    chk("w4_trace_ld_vld", s_lv, TRACE_ON ? m_lv : 1'b0);
  end

  task automatic idle();
    pc = 0; inst = 0; reg_write = 0; write_reg = 0; write_data = 0;
    mem_read = 0; mem_write = 0; mem_done = 0; mem_addr = 0;
    mem_data_in = 0; mem_data_out = 0; icache_hit = 0; dcache_hit = 0; halt = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous pulse placed between edges; outputs must clear with no clock.
  task automatic do_reset(input string tag);
    idle();
    rst = 1'b1;
    #1;
    chk({tag, "_rst_halted"}, halted, 0);
    chk({tag, "_rst_cycle"}, cycle_count, 0);
    chk({tag, "_rst_inst"}, inst_count, 0);
    chk({tag, "_rst_ireq"}, icache_req_count, 0);
    chk({tag, "_rst_dreq"}, dcache_req_count, 0);
    chk({tag, "_rst_trace"}, {trace_reg_vld, trace_ld_vld, trace_st_vld, trace_addr, trace_data}, 0);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_inputs(input bit allow_halt);
    pc = 16'($urandom); inst = 16'($urandom);
    reg_write = 1'($urandom); write_reg = 3'($urandom); write_data = 16'($urandom);
    mem_read = 1'($urandom); mem_write = ($urandom_range(0, 3) == 0);
    mem_done = 1'($urandom); mem_addr = 16'($urandom);
    mem_data_in = 16'($urandom); mem_data_out = 16'($urandom);
    icache_hit = 1'($urandom); dcache_hit = 1'($urandom);
    halt = allow_halt && ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #12;
    rst = 1'b0;

    // Reset mid-run
    for (int i = 0; i < 5; i++) begin rand_inputs(0); cyc(); end
    do_reset("midrun");
    for (int i = 0; i < 3; i++) cyc();
    chk("idle3_cycle", cycle_count, 3);
    chk("idle3_ireq", icache_req_count, 3);
    chk("idle3_inst", inst_count, 0);
    $display("txn reset_midrun cycle=%0d ireq=%0d inst=%0d", cycle_count, icache_req_count, inst_count);

    // Commit mix
    do_reset("mix");
    reg_write = 1; cyc();
    reg_write = 0; mem_write = 1; mem_done = 1; cyc();
    reg_write = 1; cyc();
    reg_write = 0; mem_done = 0; cyc();
    idle();
    chk("mix_inst", inst_count, 3);
    chk("mix_dreq", dcache_req_count, 2);
    $display("txn commit_mix inst=%0d dreq=%0d", inst_count, dcache_req_count);

    // Cache stats
    do_reset("cache");
    for (int i = 0; i < 8; i++) begin
      idle();
      icache_hit = (i < 5);
      if (i < 4) begin mem_read = 1; mem_done = 1; end
      dcache_hit = (i < 3) || (i == 4);
      cyc();
    end
    idle();
    chk("cache_dreq", dcache_req_count, 4);
    chk("cache_dhit", dcache_hit_count, 3);
    chk("cache_ihit", icache_hit_count, 5);
    chk("cache_cycle", cycle_count, 8);
    $display("txn cache dreq=%0d dhit=%0d ihit=%0d", dcache_req_count, dcache_hit_count, icache_hit_count);

    // Trace of a load
    mem_read = 1; mem_done = 1; mem_addr = 16'h0040; mem_data_out = 16'hBEEF; mem_data_in = 16'h1234;
    cyc();
    idle();
    chk("trace_ld_vld_lit", trace_ld_vld, TRACE_ON ? 1 : 0);
    chk("trace_addr_lit", trace_addr, TRACE_ON ? 16'h0040 : 16'h0);
    chk("trace_data_lit", trace_data, TRACE_ON ? 16'hBEEF : 16'h0);
    $display("txn trace_ld vld=%0d addr=%h data=%h", trace_ld_vld, trace_addr, trace_data);

    // Halt freeze
    do_reset("halt");
    for (int i = 0; i < 9; i++) cyc();
    halt = 1; cyc();
    idle();
    chk("halt_flag", halted, 1);
    chk("halt_cycle", cycle_count, 10);
    chk("halt_inst", inst_count, 1);
    for (int i = 0; i < 20; i++) begin rand_inputs(1); cyc(); end
    idle();
    chk("frozen_cycle", cycle_count, 10);
    chk("frozen_inst", inst_count, 1);
    chk("frozen_ireq", icache_req_count, 10);
    chk("frozen_halted", halted, 1);
    $display("txn halt_freeze halted=%0d cycle=%0d inst=%0d", halted, cycle_count, inst_count);

    // Saturation of the 4-bit instance
    do_reset("sat");
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_w4_cycle", s_cyc, 15);
    chk("sat_w32_cycle", cycle_count, 20);
    $display("txn saturate w4_cycle=%0d w32_cycle=%0d", s_cyc, cycle_count);

    // Randomized traffic with occasional halt and reset
    do_reset("rand");
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset("rand");
      rand_inputs(1);
      cyc();
    end
    idle();
    cyc();
    #5;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
